// File: rtl/lif_neuron_array.sv
// lif_neuron_array
//   Array of leaky-integrate-and-fire neurons. One timestep is run per accepted
//   start: every membrane potential is leaked, then one weight word per spike input
//   is read from the WVR. The weights of the inputs that spiked are accumulated
//   with saturation. Finally every neuron at or above threshold fires and resets.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   start        request one timestep (accepted only when idle)
//   clear        zero all potentials (honoured only when idle and start is low)
//   spike_vec    input spikes, latched at start
//   threshold    signed fire threshold, latched at start
//   wvr_raddr    WVR read address (k during ACCUM, 0 otherwise)
//   wvr_rdata    WVR read data, lane n = bits [n*LANE_W +: LANE_W]
//   busy         high whenever the FSM is not idle
//   done         one-cycle pulse when a timestep completes
//   spike_out    neurons that fired in the last timestep
//   pot_out      current potentials, neuron n at [n*POT_W +: POT_W]
//
// Handshake: start is a request sampled on a rising edge while busy=0. There is no
// backpressure; a start (or clear) seen while busy=1 is dropped, not queued.
// Exactly one done pulse follows each accepted start unless reset intervenes.
module lif_neuron_array #(
    parameter int NUM_NEURONS = 4,
    parameter int NUM_INPUTS  = 32,
    parameter int POT_W       = 16,
    parameter int LEAK_SHIFT  = 3,
    localparam int LANE_W     = 32 / NUM_NEURONS,
    localparam int ADDR_W     = $clog2(NUM_INPUTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         clear,
    input  logic [NUM_INPUTS-1:0]        spike_vec,
    input  logic [POT_W-1:0]             threshold,
    output logic [ADDR_W-1:0]            wvr_raddr,
    input  logic [31:0]                  wvr_rdata,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_NEURONS-1:0]       spike_out,
    output logic [NUM_NEURONS*POT_W-1:0] pot_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAK  = 3'd1,
        ACCUM = 3'd2,
        FIRE  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       cnt_q;
    logic [NUM_INPUTS-1:0]   spikes_q;
    logic signed [POT_W-1:0] thr_q;
    logic signed [POT_W-1:0] pot_q  [NUM_NEURONS];
    logic signed [POT_W-1:0] leak_v [NUM_NEURONS];
    logic signed [POT_W-1:0] acc_v  [NUM_NEURONS];

    // One extra bit of headroom is enough because a lane is narrower than a
    // potential; overflow shows up as the two top bits of the sum disagreeing.
    function automatic logic signed [POT_W-1:0] sat_add(
        input logic signed [POT_W-1:0]  v,
        input logic signed [LANE_W-1:0] w
    );
        logic [POT_W:0] s;
        s = {v[POT_W-1], v} + {{(POT_W+1-LANE_W){w[LANE_W-1]}}, w};
        if (s[POT_W] != s[POT_W-1])
            sat_add = s[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
        else
            sat_add = s[POT_W-1:0];
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LEAK;
            LEAK:    state_d = ACCUM;
            ACCUM:   if (cnt_q == ADDR_W'(NUM_INPUTS - 1)) state_d = FIRE;
            FIRE:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-neuron candidate values. A zero shift would subtract v from itself,
    // so LEAK_SHIFT=0 means "no leak" and keeps v.
    always_comb begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
            leak_v[n] = (LEAK_SHIFT == 0) ? pot_q[n] : pot_q[n] - (pot_q[n] >>> LEAK_SHIFT);
            acc_v[n]  = sat_add(pot_q[n], wvr_rdata[n*LANE_W +: LANE_W]);
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            spikes_q  <= '0;
            thr_q     <= '0;
            spike_out <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) pot_q[n] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        spikes_q <= spike_vec;
                        thr_q    <= threshold;
                        cnt_q    <= '0;
                    end else if (clear) begin
                        for (int n = 0; n < NUM_NEURONS; n++) pot_q[n] <= '0;
                    end
                end
                LEAK: begin
                    for (int n = 0; n < NUM_NEURONS; n++) pot_q[n] <= leak_v[n];
                end
                ACCUM: begin
                    if (spikes_q[cnt_q]) begin
                        for (int n = 0; n < NUM_NEURONS; n++) pot_q[n] <= acc_v[n];
                    end
                    cnt_q <= cnt_q + ADDR_W'(1);
                end
                FIRE: begin
                    for (int n = 0; n < NUM_NEURONS; n++) begin
                        if (pot_q[n] >= thr_q) begin
                            spike_out[n] <= 1'b1;
                            pot_q[n]     <= '0;
                        end else begin
                            spike_out[n] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        pot_out = '0;
        for (int n = 0; n < NUM_NEURONS; n++) pot_out[n*POT_W +: POT_W] = pot_q[n];
    end

    assign wvr_raddr = (state_q == ACCUM) ? cnt_q : '0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_lif_neuron_array.sv
// Bench for lif_neuron_array: instance a uses default parameters, instance b uses
// POT_W=12 and LEAK_SHIFT=0 so saturation is easy to reach. Both read one shared
// WVR image held in the bench.
module tb_lif_neuron_array;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, start_b, clear_a, clear_b;
    logic [31:0] spike_vec;
    logic [15:0] thr_a;
    logic [11:0] thr_b;
    logic [4:0]  raddr_a, raddr_b;
    logic [31:0] rdata_a, rdata_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [3:0]  spk_a, spk_b;
    logic [63:0] pot_a;
    logic [47:0] pot_b;

    logic [31:0] wvr [32];
    assign rdata_a = wvr[raddr_a];
    assign rdata_b = wvr[raddr_b];

    lif_neuron_array dut_a (
        .clk(clk), .reset(reset), .start(start_a), .clear(clear_a),
        .spike_vec(spike_vec), .threshold(thr_a), .wvr_raddr(raddr_a),
        .wvr_rdata(rdata_a), .busy(busy_a), .done(done_a),
        .spike_out(spk_a), .pot_out(pot_a)
    );

    lif_neuron_array #(.POT_W(12), .LEAK_SHIFT(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .clear(clear_b),
        .spike_vec(spike_vec), .threshold(thr_b), .wvr_raddr(raddr_b),
        .wvr_rdata(rdata_b), .busy(busy_b), .done(done_b),
        .spike_out(spk_b), .pot_out(pot_b)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Potentials as plain integers; leak is floor division by 2^shift.
    int mpot [2][4];

    task automatic model_ts(input int inst, input logic [31:0] sv, input int thr,
                            output logic [3:0] fired);
        int pw, ls, hi, lo, d, q, w;
        pw = (inst == 0) ? 16 : 12;
        ls = (inst == 0) ? 3 : 0;
        hi = (1 << (pw - 1)) - 1;
        lo = -(1 << (pw - 1));
        fired = '0;
        if (ls > 0) begin
            d = 1 << ls;
            for (int n = 0; n < 4; n++) begin
                q = mpot[inst][n] / d;
                if (mpot[inst][n] < 0 && (mpot[inst][n] % d) != 0) q = q - 1;
                mpot[inst][n] = mpot[inst][n] - q;
            end
        end
        for (int k = 0; k < 32; k++) begin
            if (sv[k]) begin
                for (int n = 0; n < 4; n++) begin
                    w = int'(wvr[k][n*8 +: 8]);
                    if (w > 127) w = w - 256;
                    mpot[inst][n] = mpot[inst][n] + w;
                    if (mpot[inst][n] > hi) mpot[inst][n] = hi;
                    if (mpot[inst][n] < lo) mpot[inst][n] = lo;
                end
            end
        end
        for (int n = 0; n < 4; n++) begin
            if (mpot[inst][n] >= thr) begin
                fired[n] = 1'b1;
                mpot[inst][n] = 0;
            end
        end
    endtask

    task automatic model_zero(input int inst);
        for (int n = 0; n < 4; n++) mpot[inst][n] = 0;
    endtask

    // ---------------- DUT accessors ----------------
    function automatic int dut_pot(input int inst, input int n);
        if (inst == 0) return int'($signed(pot_a[n*16 +: 16]));
        return int'($signed(pot_b[n*12 +: 12]));
    endfunction

    function automatic logic dut_done(input int inst);
        return (inst == 0) ? done_a : done_b;
    endfunction

    function automatic logic dut_busy(input int inst);
        return (inst == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic [3:0] dut_spk(input int inst);
        return (inst == 0) ? spk_a : spk_b;
    endfunction

    task automatic compare_model(input int inst, input logic [3:0] fired);
        check("spike_vs_model", dut_spk(inst), fired);
        for (int n = 0; n < 4; n++) check("pot_vs_model", dut_pot(inst, n), mpot[inst][n]);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns one falling edge after done.
    // clear_at > 0 pulses clear in that cycle of the timestep.
    task automatic run_ts(input int inst, input logic [31:0] sv, input int thr,
                          input bit cmp, input int clear_at);
        int cyc;
        bit got;
        logic [3:0] fired;
        spike_vec = sv;
        if (inst == 0) begin thr_a = 16'(thr); start_a = 1'b1; end
        else           begin thr_b = 12'(thr); start_b = 1'b1; end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            cyc++;
            clear_a = (inst == 0 && cyc == clear_at);
            clear_b = (inst == 1 && cyc == clear_at);
            if (cyc == 1) check("busy_after_start", dut_busy(inst), 1);
            if (dut_done(inst)) got = 1'b1;
        end
        clear_a = 1'b0;
        clear_b = 1'b0;
        check("done_latency", got ? cyc : -1, 35);
        model_ts(inst, sv, thr, fired);
        if (cmp) compare_model(inst, fired);
        @(negedge clk);
        check("done_one_cycle", dut_done(inst), 0);
        check("idle_after_done", dut_busy(inst), 0);
    endtask

    task automatic randomize_wvr();
        for (int k = 0; k < 32; k++) wvr[k] = $urandom;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] sv;
        int          thr;
        logic [3:0]  spk;
        logic [63:0] pot;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2000000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        bit found;
        logic [3:0] f1;
        logic [31:0] sv;

        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; clear_a = 1'b0; clear_b = 1'b0;
        spike_vec = '0; thr_a = '0; thr_b = '0;
        for (int k = 0; k < 32; k++) wvr[k] = '0;
        model_zero(0);
        model_zero(1);

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_spike", spk_a, 0);
        check("reset_pot", pot_a, 0);
        check("reset_raddr", raddr_a, 0);
        check("reset_busy_b", busy_b, 0);
        check("reset_pot_b", pot_b, 0);

        // Basic fire, leak and signed lanes (hand-derived)
        wvr[0] = 32'h0505_0505;
        wvr[1] = 32'h4040_4040;
        wvr[2] = 32'hF0F0_F0F0;
        wvr[3] = 32'h01FF_7F80;
        tbl[0] = '{32'h1, 10,    4'h0, 64'h0005_0005_0005_0005};
        tbl[1] = '{32'h1, 10,    4'hF, 64'h0000_0000_0000_0000};
        tbl[2] = '{32'h2, 100,   4'h0, 64'h0040_0040_0040_0040};
        tbl[3] = '{32'h0, 100,   4'h0, 64'h0038_0038_0038_0038};
        tbl[4] = '{32'h0, 100,   4'h0, 64'h0031_0031_0031_0031};
        tbl[5] = '{32'h0, 100,   4'h0, 64'h002B_002B_002B_002B};
        tbl[6] = '{32'h4, 100,   4'h0, 64'h0016_0016_0016_0016};
        tbl[7] = '{32'h8, 0,     4'hE, 64'h0000_0000_0000_FF94};
        tbl[8] = '{32'h8, -200,  4'hE, 64'h0000_0000_0000_FF22};
        tbl[9] = '{32'h0, 32767, 4'h0, 64'h0000_0000_0000_FF3E};
        for (int i = 0; i < 10; i++) begin
            run_ts(0, tbl[i].sv, tbl[i].thr, 1'b1, 0);
            check("table_spike", spk_a, tbl[i].spk);
            check("table_pot", pot_a, tbl[i].pot);
        end

        // Clear in IDLE
        clear_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
        check("clear_idle", pot_a, 0);
        model_zero(0);

        // Clear during ACCUM is ignored
        randomize_wvr();
        run_ts(0, $urandom, 32767, 1'b1, 0);
        run_ts(0, $urandom, 32767, 1'b1, 10);

        // start held high for 40 cycles: exactly two timesteps accepted
        sv = $urandom;
        spike_vec = sv;
        thr_a = 16'h7FFF;
        start_a = 1'b1;
        dones = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 40) start_a = 1'b0;
            if (done_a) dones++;
        end
        check("held_start_dones", dones, 2);
        model_ts(0, sv, 32767, f1);
        model_ts(0, sv, 32767, f1);
        compare_model(0, f1);

        // Saturation on the 12-bit, no-leak instance
        for (int k = 0; k < 32; k++) wvr[k] = 32'h7F7F_7F7F;
        run_ts(1, 32'hFFFF_FFFF, 2047, 1'b1, 0);
        check("sat_pos_spike", spk_b, 4'hF);
        check("sat_pos_pot", pot_b, 0);
        for (int k = 0; k < 32; k++) wvr[k] = '0;
        for (int k = 0; k < 15; k++) wvr[k] = 32'h8080_8080;
        wvr[15] = 32'h8888_8888;
        run_ts(1, 32'h0000_FFFF, 2047, 1'b1, 0);
        check("preload_neg", dut_pot(1, 2), -2040);
        for (int k = 0; k < 32; k++) wvr[k] = 32'hFFFF_FFFF;
        run_ts(1, 32'hFFFF_FFFF, 2047, 1'b1, 0);
        check("sat_neg_pot0", dut_pot(1, 0), -2048);
        check("sat_neg_pot3", dut_pot(1, 3), -2048);
        check("sat_neg_spike", spk_b, 0);

        // Randomized timesteps against the model
        for (int i = 0; i < 12; i++) begin
            randomize_wvr();
            sv = (i % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
            run_ts(0, sv, int'($urandom_range(0, 6000)) - 3000, 1'b1, 0);
        end
        for (int i = 0; i < 12; i++) begin
            randomize_wvr();
            sv = (i % 3 == 0) ? 32'hFFFF_FFFF : $urandom;
            run_ts(1, sv, int'($urandom_range(0, 4095)) - 2048, 1'b1, 0);
        end

        // Reset in the middle of ACCUM
        spike_vec = $urandom;
        thr_a = 16'h7FFF;
        start_a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (raddr_a == 5'd10) found = 1'b1;
        end
        check("reach_accum_k10", found, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", busy_a, 0);
        check("midreset_pot", pot_a, 0);
        check("midreset_raddr", raddr_a, 0);
        model_zero(0);
        model_zero(1);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        check("midreset_no_done", dones, 0);
        randomize_wvr();
        run_ts(0, $urandom, int'($urandom_range(0, 2000)) - 1000, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
